// File: rtl/ibex_mem_subsystem.sv
// Single-port RAM shared by the Ibex instruction-fetch and data ports.
// Data requests win arbitration; responses return one cycle after grant.
module ibex_mem_subsystem #(
    parameter int Depth = 16384,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          instr_req,
    output logic          instr_gnt,
    input  logic [AW-1:0] instr_addr,
    output logic          instr_rvalid,
    output logic [31:0]   instr_rdata,

    input  logic          data_req,
    output logic          data_gnt,
    input  logic          data_we,
    input  logic [3:0]    data_be,
    input  logic [AW-1:0] data_addr,
    input  logic [31:0]   data_wdata,
    output logic          data_rvalid,
    output logic [31:0]   data_rdata
);

    localparam int IW = $clog2(Depth);

    typedef enum logic {
        OWNER_INSTR = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_e;

    logic [31:0]   mem [Depth];
    logic [IW-1:0] instr_idx;
    logic [IW-1:0] data_idx;
    logic          resp_valid;
    owner_e        resp_owner;

    // Upper address bits alias and the byte offset is ignored.
    assign instr_idx = instr_addr[IW+1:2];
    assign data_idx  = data_addr[IW+1:2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{instr_addr[AW-1:IW+2], instr_addr[1:0],
                                data_addr[AW-1:IW+2], data_addr[1:0]};

    assign data_gnt  = reset & data_req;
    assign instr_gnt = reset & ~data_req & instr_req;

    // RAM storage is never reset; a store commits bytes on the grant edge.
    always_ff @(posedge clk) begin
        if (data_gnt && data_we) begin
            for (int i = 0; i < 4; i++) begin
                if (data_be[i]) begin
                    mem[data_idx][8*i +: 8] <= data_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read data is captured with the old word, so stores return the pre-write value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            resp_valid  <= 1'b0;
            resp_owner  <= OWNER_INSTR;
            instr_rdata <= 32'h0;
            data_rdata  <= 32'h0;
        end else begin
            resp_valid <= data_gnt | instr_gnt;
            if (data_gnt) begin
                resp_owner <= OWNER_DATA;
                data_rdata <= mem[data_idx];
            end else if (instr_gnt) begin
                resp_owner  <= OWNER_INSTR;
                instr_rdata <= mem[instr_idx];
            end
        end
    end

    assign instr_rvalid = resp_valid & (resp_owner == OWNER_INSTR);
    assign data_rvalid  = resp_valid & (resp_owner == OWNER_DATA);

endmodule

// File: tb/tb_ibex_mem_subsystem.sv
// Bench for ibex_mem_subsystem: directed scenarios with literal expectations,
// then random core-like traffic checked every cycle against a word-level model.
module tb_ibex_mem_subsystem;

    localparam int DEPTH = 16384;

    logic        clk;
    logic        reset;
    logic        instr_req;
    logic        instr_gnt;
    logic [31:0] instr_addr;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    logic        data_req;
    logic        data_gnt;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_rvalid;
    logic [31:0] data_rdata;

    int vectors    = 0;
    int miscompares = 0;

    ibex_mem_subsystem #(.Depth(DEPTH), .AW(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .instr_req    (instr_req),
        .instr_gnt    (instr_gnt),
        .instr_addr   (instr_addr),
        .instr_rvalid (instr_rvalid),
        .instr_rdata  (instr_rdata),
        .data_req     (data_req),
        .data_gnt     (data_gnt),
        .data_we      (data_we),
        .data_be      (data_be),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_rvalid  (data_rvalid),
        .data_rdata   (data_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: word memory keyed by index, plus the last response per port.
    logic [31:0] model_mem [int];
    bit          started  = 0;
    logic        exp_irv  = 0;
    logic        exp_drv  = 0;
    logic [31:0] exp_ir   = 0;
    logic [31:0] exp_dr   = 0;
    bit          ir_known = 0;
    bit          dr_known = 0;

    always @(posedge clk) begin
        int idx;
        logic [31:0] word;
        started = 1;
        exp_irv = 0;
        exp_drv = 0;
        if (!reset) begin
            exp_ir   = 0;
            exp_dr   = 0;
            ir_known = 1;
            dr_known = 1;
        end else if (data_req) begin
            idx     = int'((data_addr >> 2) % DEPTH);
            exp_drv = 1;
            dr_known = model_mem.exists(idx);
            if (dr_known) exp_dr = model_mem[idx];
            if (data_we) begin
                if (model_mem.exists(idx) || data_be == 4'hF) begin
                    word = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
                    for (int b = 0; b < 4; b++)
                        if (data_be[b]) word[8*b +: 8] = data_wdata[8*b +: 8];
                    model_mem[idx] = word;
                end
            end
        end else if (instr_req) begin
            idx      = int'((instr_addr >> 2) % DEPTH);
            exp_irv  = 1;
            ir_known = model_mem.exists(idx);
            if (ir_known) exp_ir = model_mem[idx];
        end
    end

    // Compare process: grants against the current inputs, responses against the model.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (started) begin
                check_output("data_gnt",     {31'b0, data_gnt},     {31'b0, reset & data_req});
                check_output("instr_gnt",    {31'b0, instr_gnt},    {31'b0, reset & ~data_req & instr_req});
                check_output("instr_rvalid", {31'b0, instr_rvalid}, {31'b0, exp_irv});
                check_output("data_rvalid",  {31'b0, data_rvalid},  {31'b0, exp_drv});
                if (ir_known) check_output("instr_rdata", instr_rdata, exp_ir);
                if (dr_known) check_output("data_rdata",  data_rdata,  exp_dr);
            end
        end
    end

    task automatic apply_stimulus(input logic rst, input logic ireq, input logic [31:0] iaddr,
                                  input logic dreq, input logic we, input logic [3:0] be,
                                  input logic [31:0] daddr, input logic [31:0] wdata);
        @(negedge clk);
        reset      = rst;
        instr_req  = ireq;
        instr_addr = iaddr;
        data_req   = dreq;
        data_we    = we;
        data_be    = be;
        data_addr  = daddr;
        data_wdata = wdata;
        #2;
    endtask

    task automatic idle();
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    logic [31:0] prog [8] = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00308193,
                              32'h00410213, 32'h00518293, 32'h00620313, 32'h00728393};

    initial begin
        bit          i_pend;
        bit          d_pend;
        logic [31:0] a;
        reset = 0; instr_req = 1; instr_addr = 32'h80;
        data_req = 0; data_we = 0; data_be = 0; data_addr = 0; data_wdata = 0;

        // Reset held two cycles with a pending fetch.
        apply_stimulus(0, 1, 32'h80, 0, 0, 0, 0, 0);
        check_output("rst instr_gnt", {31'b0, instr_gnt}, 32'd0);
        check_output("rst rvalid", {30'b0, instr_rvalid, data_rvalid}, 32'd0);
        apply_stimulus(0, 1, 32'h80, 0, 0, 0, 0, 0);
        check_output("rst instr_gnt 2", {31'b0, instr_gnt}, 32'd0);
        check_output("rst rdata", instr_rdata | data_rdata, 32'd0);
        apply_stimulus(1, 1, 32'h80, 0, 0, 0, 0, 0);
        check_output("post-rst instr_gnt", {31'b0, instr_gnt}, 32'd1);
        idle();
        check_output("post-rst instr_rvalid", {31'b0, instr_rvalid}, 32'd1);

        // Preload program words and the 0x200 word through the data port.
        for (int k = 0; k < 8; k++)
            apply_stimulus(1, 0, 0, 1, 1, 4'hF, 32'h80 + 32'(4*k), prog[k]);
        apply_stimulus(1, 0, 0, 1, 1, 4'hF, 32'h200, 32'h11111111);
        idle();

        // Single fetch.
        apply_stimulus(1, 1, 32'h80, 0, 0, 0, 0, 0);
        check_output("fetch gnt", {31'b0, instr_gnt}, 32'd1);
        idle();
        check_output("fetch rvalid", {31'b0, instr_rvalid}, 32'd1);
        check_output("fetch rdata", instr_rdata, 32'h00000013);
        check_output("fetch data_rvalid", {31'b0, data_rvalid}, 32'd0);

        // Byte-enable merge.
        apply_stimulus(1, 0, 0, 1, 1, 4'hF, 32'h100, 32'hDEADBEEF);
        check_output("store gnt", {31'b0, data_gnt}, 32'd1);
        apply_stimulus(1, 0, 0, 1, 1, 4'b0001, 32'h100, 32'h000000AA);
        check_output("store1 rvalid", {31'b0, data_rvalid}, 32'd1);
        apply_stimulus(1, 0, 0, 1, 0, 4'hF, 32'h100, 0);
        check_output("store2 rvalid", {31'b0, data_rvalid}, 32'd1);
        idle();
        check_output("merge rdata", data_rdata, 32'hDEADBEAA);

        // Simultaneous requests: data first, fetch the cycle after.
        apply_stimulus(1, 1, 32'h80, 1, 0, 4'hF, 32'h200, 0);
        check_output("both data_gnt", {31'b0, data_gnt}, 32'd1);
        check_output("both instr_gnt", {31'b0, instr_gnt}, 32'd0);
        apply_stimulus(1, 1, 32'h80, 0, 0, 0, 0, 0);
        check_output("both data_rvalid", {31'b0, data_rvalid}, 32'd1);
        check_output("both data_rdata", data_rdata, 32'h11111111);
        check_output("both instr_gnt late", {31'b0, instr_gnt}, 32'd1);
        idle();
        check_output("both instr_rvalid", {31'b0, instr_rvalid}, 32'd1);
        check_output("both instr_rdata", instr_rdata, 32'h00000013);

        // Aliasing above the RAM span.
        apply_stimulus(1, 0, 0, 1, 1, 4'hF, 32'h00010004, 32'h12345678);
        apply_stimulus(1, 0, 0, 1, 0, 4'hF, 32'h00000004, 0);
        idle();
        check_output("alias rdata", data_rdata, 32'h12345678);

        // Eight back-to-back fetches.
        for (int k = 0; k < 8; k++) begin
            apply_stimulus(1, 1, 32'h80 + 32'(4*k), 0, 0, 0, 0, 0);
            check_output("b2b gnt", {31'b0, instr_gnt}, 32'd1);
            if (k > 0) begin
                check_output("b2b rvalid", {31'b0, instr_rvalid}, 32'd1);
                check_output("b2b rdata", instr_rdata, prog[k-1]);
            end
        end
        idle();
        check_output("b2b last rdata", instr_rdata, prog[7]);

        // Reset on the fourth grant cycle drops that grant.
        for (int k = 0; k < 3; k++) apply_stimulus(1, 1, 32'h80 + 32'(4*k), 0, 0, 0, 0, 0);
        apply_stimulus(0, 1, 32'h8C, 0, 0, 0, 0, 0);
        check_output("midrst gnt", {31'b0, instr_gnt}, 32'd0);
        check_output("midrst prev rvalid", {31'b0, instr_rvalid}, 32'd1);
        apply_stimulus(1, 1, 32'h8C, 0, 0, 0, 0, 0);
        check_output("midrst dropped rvalid", {31'b0, instr_rvalid}, 32'd0);
        check_output("midrst rdata cleared", instr_rdata, 32'd0);
        idle();
        check_output("midrst refetch rdata", instr_rdata, prog[3]);

        // Random core-like traffic: requests and their fields are held until granted.
        i_pend = 0;
        d_pend = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 99) != 0);
            if (!i_pend) begin
                instr_req = 1'($urandom());
                a = $urandom();
                a[15:2] = 14'(32'h20 + $urandom_range(0, 63));
                instr_addr = a;
            end
            if (!d_pend) begin
                data_req   = ($urandom_range(0, 2) == 0);
                data_we    = 1'($urandom());
                data_be    = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom());
                a = $urandom();
                a[15:2] = 14'(32'h20 + $urandom_range(0, 63));
                data_addr  = a;
                data_wdata = $urandom();
            end
            d_pend = data_req && !reset;
            i_pend = instr_req && !(reset && !data_req);
        end
        idle();
        idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
